// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight destination registers, stalls on
// read-after-write hazards and sequences branch/jump redirects. State updates on the falling CLK edge.
//
// state      | meaning
// IDLE       | decode normally; evaluate jump, data hazard, branch
// STALL      | data-hazard bubbles remaining (cnt)
// BR_WAIT    | branch decoded, waiting for ALUZero4 (cnt)
// BR_RESOLVE | ALUZero4 valid; redirect if taken
// REDIRECT   | flush after a taken branch
// JUMP       | flush after a jump
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int HIST_DEPTH = 3,
  parameter int BR_LAT     = 2,
  parameter bit FWD_EN     = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Branch,
  input  logic              ALUZero4,
  input  logic              Jump,
  input  logic [REG_AW-1:0] rw,
  input  logic              MemRead,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              UseRs,
  input  logic              UseRt,
  output logic              PCWrite,
  output logic              IFWrite,
  output logic              Bubble,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int CW = $clog2(8);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    STALL      = 3'd1,
    BR_WAIT    = 3'd2,
    BR_RESOLVE = 3'd3,
    REDIRECT   = 3'd4,
    JUMP       = 3'd5
  } state_t;

  state_t                               state_q, state_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic [HIST_DEPTH:1][REG_AW-1:0]      rw_h_q, rw_h_d;
  logic [HIST_DEPTH:1]                  ld_h_q, ld_h_d;
  logic [CNT_W-1:0]                     stall_cnt_q, stall_cnt_d;

  logic [HIST_DEPTH:1]                  match;
  logic                                 hz;
  logic [CW-1:0]                        hz_n;

  always_comb begin
    for (int i = 1; i <= HIST_DEPTH; i++) begin
      match[i] = (rw_h_q[i] != '0) &&
                 ((UseRs && (rs == rw_h_q[i])) || (UseRt && (rt == rw_h_q[i])));
    end
  end

  // Without forwarding the nearest producer sets the stall length.
  always_comb begin
    hz   = 1'b0;
    hz_n = '0;
    if (FWD_EN) begin
      if (match[1] && ld_h_q[1]) begin
        hz   = 1'b1;
        hz_n = CW'(1);
      end
    end else begin
      for (int i = HIST_DEPTH; i >= 1; i--) begin
        if (match[i]) begin
          hz   = 1'b1;
          hz_n = CW'(HIST_DEPTH + 1 - i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    PCWrite = 1'b0;
    IFWrite = 1'b0;
    Bubble  = 1'b1;
    case (state_q)
      IDLE: begin
        if (Jump) begin
          PCWrite = 1'b1;
          Bubble  = 1'b0;
          state_d = JUMP;
        end else if (hz) begin
          if (hz_n != CW'(1)) begin
            state_d = STALL;
            cnt_d   = hz_n - CW'(1);
          end
        end else if (Branch) begin
          Bubble  = 1'b0;
          state_d = BR_WAIT;
          cnt_d   = CW'(BR_LAT - 1);
        end else begin
          PCWrite = 1'b1;
          IFWrite = 1'b1;
          Bubble  = 1'b0;
        end
      end
      STALL: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = IDLE;
      end
      BR_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = BR_RESOLVE;
      end
      BR_RESOLVE: begin
        PCWrite = 1'b1;
        if (ALUZero4) begin
          state_d = REDIRECT;
        end else begin
          IFWrite = 1'b1;
          state_d = IDLE;
        end
      end
      REDIRECT, JUMP: begin
        PCWrite = 1'b1;
        IFWrite = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (Reset) begin
      PCWrite = 1'b0;
      IFWrite = 1'b0;
      Bubble  = 1'b1;
    end
  end

  // A squashed instruction never becomes a producer.
  always_comb begin
    rw_h_d    = rw_h_q;
    ld_h_d    = ld_h_q;
    rw_h_d[1] = Bubble ? '0 : rw;
    ld_h_d[1] = Bubble ? 1'b0 : MemRead;
    for (int i = 2; i <= HIST_DEPTH; i++) begin
      rw_h_d[i] = rw_h_q[i-1];
      ld_h_d[i] = ld_h_q[i-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((!IFWrite || Bubble) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(negedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_h_q      <= '0;
      ld_h_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_h_q      <= rw_h_d;
      ld_h_q      <= ld_h_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- REG_AW, 5: register-address width.
- HIST_DEPTH, 3: number of in-flight producer stages tracked (1..7).
- BR_LAT, 2: cycles from branch decode to ALUZero4 valid (2..7).
- FWD_EN, 0: 1 = forwarding present, so only load-use hazards stall.
- CNT_W, 16: StallCount width.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK, in, 1: clock; all state updates on the falling edge.
- Reset, in, 1: synchronous, active-high reset, sampled on the CLK falling edge.
- Branch, in, 1: decoded instruction is a conditional branch.
- ALUZero4, in, 1: branch-taken flag, valid in BR_RESOLVE.
- Jump, in, 1: decoded instruction is a jump.
- rw, in, REG_AW: destination register of the decoded instruction; 0 = none.
- MemRead, in, 1: decoded instruction is a load.
- rs, in, REG_AW: source register A of the decoded instruction.
- rt, in, REG_AW: source register B of the decoded instruction.
- UseRs, in, 1: rs is actually read.
- UseRt, in, 1: rt is actually read.
- PCWrite, out, 1: PC update enable.
- IFWrite, out, 1: IF/ID register write enable.
- Bubble, out, 1: squash the decoded instruction (insert a NOP).
- StallCount, out, CNT_W: saturating count of lost cycles.

Function
REQ-003 History: rw_h[1..HIST_DEPTH] and ld_h[1..HIST_DEPTH] SHALL shift every falling edge.
- rw_h[1] <= Bubble ? 0 : rw; ld_h[1] <= Bubble ? 0 : MemRead.
- rw_h[i] <= rw_h[i-1] and ld_h[i] <= ld_h[i-1], for i >= 2.

REQ-004 match(i) SHALL be 1 iff rw_h[i] != 0 and ((UseRs and rs == rw_h[i]) or (UseRt and rt == rw_h[i])).

REQ-005 With FWD_EN=0, hazard distance i SHALL be the smallest matching index, and the stall length SHALL be n = HIST_DEPTH + 1 - i.

REQ-006 With FWD_EN=1, a hazard SHALL exist only when match(1) and ld_h[1] are both 1, with n = 1; all other matches SHALL be ignored.

REQ-007 Outputs SHALL be combinational (Mealy) from state and inputs; tuple notation is (PCWrite, IFWrite, Bubble).

REQ-008 States SHALL be IDLE, STALL, BR_WAIT, BR_RESOLVE, REDIRECT and JUMP, with a down-counter cnt of width clog2(8).

REQ-009 IDLE SHALL apply this priority, highest first:
- Jump -> (1,0,0), next JUMP.
- Data hazard -> (0,0,1); next IDLE if n = 1, else STALL with cnt = n-1.
- Branch -> (0,0,0), next BR_WAIT with cnt = BR_LAT-1.
- Otherwise -> (1,1,0), stay in IDLE.

REQ-010 STALL SHALL output (0,0,1), decrement cnt, and go to IDLE when cnt = 1.

REQ-011 BR_WAIT SHALL output (0,0,1), decrement cnt, and go to BR_RESOLVE when cnt = 1.

REQ-012 BR_RESOLVE SHALL behave as follows:
- ALUZero4 = 1 -> (1,0,1), next REDIRECT.
- ALUZero4 = 0 -> (1,1,1), next IDLE.

REQ-013 REDIRECT and JUMP SHALL each output (1,1,1) and go to IDLE.

REQ-014 Jump, Branch and hazard inputs SHALL be ignored outside IDLE.

REQ-015 An illegal state encoding SHALL output (0,0,1) and go to IDLE.

REQ-016 StallCount SHALL increment on each falling edge where IFWrite = 0 or Bubble = 1, and saturate at all-ones.

Reset
REQ-017 Reset SHALL take effect on the next falling edge and SHALL win over every other event, including mid-STALL and mid-branch:
- state -> IDLE, cnt -> 0;
- all rw_h and ld_h entries -> 0;
- StallCount -> 0.

REQ-018 While Reset = 1, outputs SHALL be forced to (0,0,1).

REQ-019 The first cycle after Reset deasserts, with no Jump or Branch, SHALL output (1,1,0).

Verification
REQ-020 Defaults, FWD_EN=0: rw=5 issued, next instruction rs=5, UseRs=1 -> (0,0,1) for 3 cycles, then (1,1,0); StallCount = 3.

REQ-021 FWD_EN=1: load rw=8, MemRead=1, followed by rt=8, UseRt=1 -> exactly 1 bubble. The same pair with MemRead=0 -> 0 bubbles.

REQ-022 False hazards: rs=0 with rw_h all 0, or rs=rw_h[1]=3 with UseRs=0 -> (1,1,0) every cycle; StallCount stays 0.

REQ-023 Branch, BR_LAT=2:
- taken -> (0,0,0), (0,0,1), (1,0,1), (1,1,1), then (1,1,0);
- not taken -> (0,0,0), (0,0,1), (1,1,1), then (1,1,0).

REQ-024 Jump=1 together with a distance-1 hazard in IDLE -> (1,0,0), then (1,1,1), then hazard evaluation resumes.

REQ-025 Reset asserted during STALL with cnt = 2 -> (0,0,1) while asserted; after release: IDLE, history empty, StallCount = 0, outputs (1,1,0).
